// File: rtl/axi_burst_mem.sv
// ---------------------------------------------------------------------------
// axi_burst_mem
//   Small AXI-style word memory (DEPTH x 32 bits) with independent INCR-style
//   write and read burst engines.  Burst indices wrap modulo DEPTH, so a long
//   burst sweeps the memory repeatedly.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   awaddr/awlen/awvalid/awready write burst address (byte addr, len-1)
//   wdata/wstrb/wvalid/wready    write data beats with byte enables
//   bvalid/bready                write response
//   araddr/arlen/arvalid/arready read burst address (byte addr, len-1)
//   rdata/rvalid/rready          registered read data beats
//
// Parameters
//   DEPTH  number of 32-bit words, power of two in 2..256
// ---------------------------------------------------------------------------
module axi_burst_mem #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic        rvalid,
  input  logic        rready
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e          w_state_q, w_state_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic [7:0]        w_cnt_q, w_cnt_d;
  logic              w_we;

  r_state_e          r_state_q, r_state_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic [7:0]        r_cnt_q, r_cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  // Low while in reset and for nothing else: keeps awready/arready at 0
  // during reset even though both FSMs sit in their idle states, and lets
  // them rise on the first rising edge after reset_n is released.
  logic              live_q;

  logic [31:0]       mem_q [DEPTH];

  // Address bits outside the word index are deliberately ignored.
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{awaddr[31:IDX_W+2], awaddr[1:0],
                              araddr[31:IDX_W+2], araddr[1:0]};

  // -------------------------------------------------------------------------
  // Write FSM: next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_cnt_d   = w_cnt_q;
    w_we      = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready = live_q;
        if (live_q && awvalid) begin
          w_idx_d   = awaddr[IDX_W+1:2];
          w_cnt_d   = awlen;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          w_we    = 1'b1;
          // Natural overflow of the IDX_W-bit index gives the modulo-DEPTH wrap.
          w_idx_d = w_idx_q + 1'b1;
          if (w_cnt_q == 8'd0) begin
            w_state_d = W_RESP;
          end else begin
            w_cnt_d = w_cnt_q - 8'd1;
          end
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Read FSM: next state, outputs and next rdata.  Loads read mem_q as it
  // stands before this edge, so a write on the same edge is not seen.
  // -------------------------------------------------------------------------
  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_cnt_d   = r_cnt_q;
    rdata_d   = rdata_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = live_q;
        if (live_q && arvalid) begin
          rdata_d   = mem_q[araddr[IDX_W+1:2]];
          r_idx_d   = araddr[IDX_W+1:2] + 1'b1;
          r_cnt_d   = arlen;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) begin
          if (r_cnt_q == 8'd0) begin
            r_state_d = R_IDLE;
          end else begin
            // r_idx_q already points at the next beat's word.
            rdata_d = mem_q[r_idx_q];
            r_idx_d = r_idx_q + 1'b1;
            r_cnt_d = r_cnt_q - 8'd1;
          end
        end
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      live_q    <= 1'b0;
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_cnt_q   <= '0;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
    end else begin
      live_q    <= 1'b1;
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_cnt_q   <= w_cnt_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_cnt_q   <= r_cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Memory array with byte-lane writes; cleared by reset
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem_q[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_axi_burst_mem.sv
// ---------------------------------------------------------------------------
// tb_axi_burst_mem
//   Directed and randomized bursts against a word-array model of the memory.
// ---------------------------------------------------------------------------
module tb_axi_burst_mem;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] model [DEPTH];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  bit          pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  axi_burst_mem #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arlen   (arlen),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  // Word index of beat b of a burst starting at byte address a.
  function automatic int widx(input logic [31:0] a, input int b);
    int base;
    base = int'((a >> 2) % DEPTH);
    return (base + b) % DEPTH;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
  endtask

  // Write burst using wd[]/ws[]; random data gaps, stray wvalid while not in
  // the data phase, and bdelay cycles of bready=0 before the response.
  task automatic do_write(input logic [31:0] addr, input int len, input int bdelay);
    @(negedge clk);
    awaddr  = addr;
    awlen   = 8'(len);
    awvalid = 1'b1;
    if ($urandom_range(0, 1) == 1) begin
      wvalid = 1'b1;
      wdata  = $urandom();
      wstrb  = 4'hF;
    end
    for (int t = 0; t < 20 && !awready; t++) @(negedge clk);
    chk("awready_idle", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(negedge clk);
      end
      chk("wready_data", 32'(wready), 32'd1);
      wdata  = wd[b];
      wstrb  = ws[b];
      wvalid = 1'b1;
      @(negedge clk);
      model_write(widx(addr, b), wd[b], ws[b]);
    end
    wvalid = 1'b0;
    chk("bvalid_resp", 32'(bvalid), 32'd1);
    chk("awready_resp", 32'(awready), 32'd0);
    chk("wready_resp", 32'(wready), 32'd0);
    for (int t = 0; t < bdelay; t++) begin
      wvalid = 1'b1;
      wdata  = $urandom();
      wstrb  = 4'hF;
      @(negedge clk);
      wvalid = 1'b0;
      chk("bvalid_hold", 32'(bvalid), 32'd1);
      chk("awready_hold", 32'(awready), 32'd0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_done", 32'(bvalid), 32'd0);
    chk("awready_back", 32'(awready), 32'd1);
  endtask

  // Read burst; mode 0: rready always 1, 1: random, 2: pattern 0,1,0,0,1...
  task automatic do_read(input logic [31:0] addr, input int len, input int mode);
    int          p;
    bit          rr;
    logic [31:0] want;
    p = 0;
    @(negedge clk);
    araddr  = addr;
    arlen   = 8'(len);
    arvalid = 1'b1;
    for (int t = 0; t < 20 && !arready; t++) @(negedge clk);
    chk("arready_idle", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      want = model[widx(addr, b)];
      for (int s = 0; s < 8; s++) begin
        chk("rvalid_beat", 32'(rvalid), 32'd1);
        chk("rdata_beat", rdata, want);
        case (mode)
          0:       rr = 1'b1;
          1:       rr = 1'($urandom_range(0, 1));
          default: begin rr = pat[p % 5]; p++; end
        endcase
        if (s == 7) rr = 1'b1;
        rready = rr;
        @(negedge clk);
        rready = 1'b0;
        if (rr) break;
      end
    end
    chk("rvalid_end", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  // Write and read bursts of equal length launched on the same edge, both
  // stepping every cycle; every read beat is loaded no later than the edge
  // that writes its word, so all read beats must return the old contents.
  task automatic do_conc(input logic [31:0] wa, input logic [31:0] ra, input int len);
    logic [31:0] old [4];
    for (int b = 0; b <= len; b++) old[b] = model[widx(ra, b)];
    @(negedge clk);
    awaddr  = wa;
    awlen   = 8'(len);
    awvalid = 1'b1;
    araddr  = ra;
    arlen   = 8'(len);
    arvalid = 1'b1;
    chk("conc_awready", 32'(awready), 32'd1);
    chk("conc_arready", 32'(arready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    arvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      chk("conc_rvalid", 32'(rvalid), 32'd1);
      chk("conc_rdata_old", rdata, old[b]);
      wdata  = wd[b];
      wstrb  = 4'hF;
      wvalid = 1'b1;
      rready = 1'b1;
      @(negedge clk);
      model_write(widx(wa, b), wd[b], 4'hF);
    end
    wvalid = 1'b0;
    rready = 1'b0;
    chk("conc_rvalid_end", 32'(rvalid), 32'd0);
    chk("conc_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("conc_bvalid_done", 32'(bvalid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    awaddr  = '0; awlen = '0; awvalid = 1'b0;
    wdata   = '0; wstrb = '0; wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = '0; arlen = '0; arvalid = 1'b0;
    rready  = 1'b0;
    model_clear();

    // Reset state, then ready flags on the first edge after release
    repeat (2) @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 32'(awready), 32'd1);
    chk("post_rst_arready", 32'(arready), 32'd1);

    // Single write / read
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h08, 0, 0);
    do_read(32'h08, 0, 0);

    // Byte strobes
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(32'h04, 0, 1);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    do_write(32'h04, 0, 2);
    do_read(32'h04, 0, 1);

    // Wrapping burst across the top of memory
    for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
    do_write(32'h38, 3, 0);
    do_read(32'h38, 3, 0);
    do_read(32'h00, 1, 0);

    // Read backpressure pattern
    do_read(32'h38, 3, 2);

    // Same-cycle write and read bursts
    wd[0] = $urandom();
    do_conc(32'h10, 32'h10, 0);
    for (int b = 0; b < 3; b++) wd[b] = $urandom();
    do_conc(32'h24, 32'h20, 2);
    for (int b = 0; b < 4; b++) wd[b] = $urandom();
    do_conc(32'hFFFF_FF34, 32'h0000_0034, 3);

    // Randomized bursts, full address range, random strobes (including 0)
    for (int it = 0; it < 25; it++) begin
      int len;
      len = int'($urandom_range(0, 20));
      for (int b = 0; b <= len; b++) begin
        wd[b] = $urandom();
        ws[b] = 4'($urandom_range(0, 15));
      end
      do_write($urandom(), len, int'($urandom_range(0, 3)));
      do_read($urandom(), int'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
    end

    // Maximum-length burst sweeping the memory 16 times
    for (int b = 0; b < 256; b++) begin
      wd[b] = $urandom();
      ws[b] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
    end
    do_write(32'h3C, 255, 1);
    do_read(32'h00, 255, 0);

    // Reset in the middle of a 4-beat write burst after 2 beats
    for (int b = 0; b < 4; b++) wd[b] = $urandom() | 32'h1;
    @(negedge clk);
    awaddr  = 32'h20;
    awlen   = 8'd3;
    awvalid = 1'b1;
    chk("mid_awready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b1; wstrb = 4'hF; wdata = wd[0];
    @(negedge clk);
    wdata = wd[1];
    @(negedge clk);
    wvalid = 1'b0;
    chk("mid_wready", 32'(wready), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_wready", 32'(wready), 32'd0);
    chk("async_awready", 32'(awready), 32'd0);
    chk("async_arready", 32'(arready), 32'd0);
    chk("async_bvalid", 32'(bvalid), 32'd0);
    chk("async_rvalid", 32'(rvalid), 32'd0);
    chk("async_rdata", rdata, 32'd0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("abandon_bvalid", 32'(bvalid), 32'd0);
      chk("abandon_awready", 32'(awready), 32'd1);
    end
    do_read(32'h00, 15, 0);

    // Normal operation after reset
    for (int b = 0; b < 3; b++) begin wd[b] = $urandom(); ws[b] = 4'hF; end
    do_write(32'h20, 2, 1);
    do_read(32'h1C, 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_burst_mem.md
AXI_BURST_MEM -- requirements
Module: axi_burst_mem

Parameters
REQ-001 The block SHALL have parameter DEPTH, default 16, giving the number of 32-bit memory words; DEPTH SHALL be a power of two, range 2..256.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset; asynchronous, active-low.
REQ-004 The block SHALL have port awaddr, input, 32 bits: write burst start byte address.
REQ-005 The block SHALL have port awlen, input, 8 bits: write burst length minus one.
REQ-006 The block SHALL have ports awvalid (input, 1 bit) and awready (output, 1 bit): write address handshake.
REQ-007 The block SHALL have ports wdata (input, 32 bits) and wstrb (input, 4 bits): write data and byte enables.
REQ-008 The block SHALL have ports wvalid (input, 1 bit) and wready (output, 1 bit): write data handshake.
REQ-009 The block SHALL have ports bvalid (output, 1 bit) and bready (input, 1 bit): write response handshake.
REQ-010 The block SHALL have ports araddr (input, 32 bits) and arlen (input, 8 bits): read burst start byte address and length minus one.
REQ-011 The block SHALL have ports arvalid (input, 1 bit) and arready (output, 1 bit): read address handshake.
REQ-012 The block SHALL have ports rdata (output, 32 bits), rvalid (output, 1 bit) and rready (input, 1 bit): read data channel.

Function
REQ-013 The block SHALL compute word index as addr[log2(DEPTH)+1:2]; addr[1:0] ignored; upper bits ignored.
REQ-014 The block SHALL increment the burst index by 1 per accepted beat, wrapping modulo DEPTH (DEPTH-1 -> 0).
REQ-015 The write FSM SHALL have states W_IDLE, W_DATA and W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-016 In W_IDLE, awvalid=1 SHALL capture the index and awlen and move to W_DATA on the next edge.
REQ-017 In W_DATA, each beat with wvalid&&wready SHALL write byte lane i of mem[idx] from wdata[8i+7:8i] if and only if wstrb[i]=1.
REQ-018 A beat with wstrb=0 SHALL still count as a beat.
REQ-019 After beat awlen+1 is accepted, the write FSM SHALL enter W_RESP.
REQ-020 W_RESP SHALL hold bvalid until the edge where bready=1, then return to W_IDLE; awready SHALL not reassert before that edge.
REQ-021 The read FSM SHALL have states R_IDLE and R_DATA, independent of the write FSM; arready=1 only in R_IDLE, rvalid=1 only in R_DATA.
REQ-022 On arvalid in R_IDLE, the block SHALL capture the index and arlen, and next cycle present rvalid=1 with rdata=mem[start] (one cycle address-to-data latency).
REQ-023 rdata SHALL be a register, stable while rvalid=1 and rready=0.
REQ-024 On each rvalid&&rready edge, the block SHALL load rdata from the next wrapped index if beats remain; after beat arlen+1, rvalid SHALL drop and the FSM SHALL return to R_IDLE.
REQ-025 With back-to-back rready=1, the block SHALL produce one beat per cycle.
REQ-026 rdata loads SHALL sample memory contents before any write on the same edge; a same-edge write is visible only to later loads.
REQ-027 Simultaneous AW and AR handshakes in one cycle SHALL both be accepted.
REQ-028 awlen=0 and arlen=0 SHALL give single-beat bursts; awlen=255 with DEPTH=16 SHALL wrap the memory repeatedly, with later beats overwriting earlier ones.
REQ-029 wvalid in W_IDLE or W_RESP SHALL be ignored (wready=0, no write).

Reset
REQ-030 reset_n=0 SHALL force, asynchronously: W_IDLE, R_IDLE, awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rdata=0, all memory words=0, and burst counters=0.
REQ-031 awready and arready SHALL assert on the first rising edge after reset_n deasserts.
REQ-032 Reset mid-burst SHALL abandon the burst with no response; words already written are cleared.

Verification
REQ-033 Single write: awaddr=0x08, awlen=0, wdata=0xDEADBEEF, wstrb=0xF, bready=1 -> bvalid one cycle; read of 0x08 returns 0xDEADBEEF.
REQ-034 Byte strobes: write 0x11223344 to 0x04, then 0xAABBCCDD with wstrb=0x5 -> read returns 0x11BB33DD.
REQ-035 Wrapping burst: DEPTH=16, awaddr=0x38, awlen=3, data 1,2,3,4 -> words 14,15,0,1 hold 1,2,3,4; 4-beat read from 0x38 returns 1,2,3,4.
REQ-036 Read backpressure: 4-beat read with rready toggled 0,1,0,0,1,... -> each rdata held stable while stalled, with exactly 4 beats in order.
REQ-037 Concurrency: write burst and read burst to the same address started in the same cycle -> both complete; the read beat loaded before the write edge returns the old value.
REQ-038 Reset mid write burst after 2 of 4 beats -> bvalid never asserts; all words read 0; the next write is accepted normally.
